// File: rtl/mips_defs.sv
// Shared MIPS definitions: supported opcodes, loader state encoding and
// the default frame start marker.
package mips_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_LEN_HI = 3'd1,
    LD_LEN_LO = 3'd2,
    LD_DATA   = 3'd3,
    LD_CSUM   = 3'd4,
    LD_DONE   = 3'd5,
    LD_ERROR  = 3'd6
  } ld_state_e;

endpackage

// File: rtl/imem_loader_op_supported.sv
// Combinational membership test of a 6-bit opcode against the supported
// MIPS subset; shared by the loader and decoder checkers.
module op_supported
  import mips_defs::*;
(
  input  logic [5:0] i_opcode,
  output logic       o_supported
);

  // Opcode membership lookup
  always_comb begin
    case (i_opcode)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI,
      OP_ORI, OP_LUI, OP_SLTI, OP_J, OP_JAL: o_supported = 1'b1;
      default:                               o_supported = 1'b0;
    endcase
  end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: assembles big-endian instruction words, writes
// them to imem, checks the XOR checksum and then releases the CPU reset.
module imem_loader
  import mips_defs::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = {ADDR_WIDTH{1'b0}},
  parameter logic [7:0]            SYNC_BYTE  = SYNC_BYTE_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [7:0]            warn_count
);

  localparam logic [16:0]         CAPACITY = 17'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] WC_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  ld_state_e             r_state;
  ld_state_e             w_next;
  logic [15:0]           r_len;
  logic [23:0]           r_asm;
  logic [1:0]            r_byte_cnt;
  logic [7:0]            r_csum;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [ADDR_WIDTH:0]   r_word_count;
  logic [7:0]            r_warn_count;

  logic                  w_accept;
  logic [15:0]           w_len;
  logic [31:0]           w_word;
  logic                  w_op_ok;
  logic                  w_all_written;

  assign w_accept      = rx_valid && rx_ready;
  assign w_len         = {r_len[15:8], rx_data};
  assign w_word        = {r_asm, rx_data};
  assign w_all_written = (32'(r_word_count) == 32'(r_len));

  op_supported u_op_supported (
    .i_opcode    (w_word[31:26]),
    .o_supported (w_op_ok)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LD_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; DATA leaves only once the final write has been issued
  always_comb begin
    w_next = r_state;
    case (r_state)
      LD_IDLE: begin
        if (w_accept && (rx_data == SYNC_BYTE)) w_next = LD_LEN_HI;
        else                                    w_next = LD_IDLE;
      end
      LD_LEN_HI: begin
        if (w_accept) w_next = LD_LEN_LO;
        else          w_next = LD_LEN_HI;
      end
      LD_LEN_LO: begin
        if (!w_accept)                        w_next = LD_LEN_LO;
        else if ({1'b0, w_len} > CAPACITY)    w_next = LD_ERROR;
        else if (w_len == 16'd0)              w_next = LD_CSUM;
        else                                  w_next = LD_DATA;
      end
      LD_DATA: begin
        if (r_we && w_all_written) w_next = LD_CSUM;
        else                       w_next = LD_DATA;
      end
      LD_CSUM: begin
        if (!w_accept)             w_next = LD_CSUM;
        else if (rx_data == r_csum) w_next = LD_DONE;
        else                       w_next = LD_ERROR;
      end
      LD_DONE:  w_next = LD_DONE;
      LD_ERROR: w_next = LD_ERROR;
      default:  w_next = LD_ERROR;
    endcase
  end

  // Datapath: length latch, word assembly, checksum, write issue and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_len        <= 16'd0;
      r_asm        <= 24'd0;
      r_byte_cnt   <= 2'd0;
      r_csum       <= 8'd0;
      r_we         <= 1'b0;
      r_addr       <= BASE_ADDR;
      r_wdata      <= 32'd0;
      r_word_count <= {(ADDR_WIDTH+1){1'b0}};
      r_warn_count <= 8'd0;
    end else begin
      r_we <= 1'b0;
      if (w_accept) begin
        case (r_state)
          LD_LEN_HI: r_len[15:8] <= rx_data;
          LD_LEN_LO: r_len[7:0]  <= rx_data;
          LD_DATA: begin
            r_csum     <= r_csum ^ rx_data;
            r_asm      <= {r_asm[15:0], rx_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_we         <= 1'b1;
              r_wdata      <= w_word;
              r_addr       <= BASE_ADDR + r_word_count[ADDR_WIDTH-1:0];
              r_word_count <= r_word_count + WC_ONE;
              if (!w_op_ok && (r_warn_count != 8'hFF)) begin
                r_warn_count <= r_warn_count + 8'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Handshake and status decode from the registered state
  always_comb begin
    rx_ready  = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    cpu_reset = 1'b1;
    case (r_state)
      LD_IDLE, LD_LEN_HI, LD_LEN_LO, LD_CSUM: rx_ready = 1'b1;
      LD_DATA:  rx_ready = !r_we;
      LD_DONE: begin
        rx_ready  = 1'b0;
        done      = 1'b1;
        cpu_reset = 1'b0;
      end
      LD_ERROR: begin
        rx_ready = 1'b0;
        error    = 1'b1;
      end
      default: begin
        rx_ready = 1'b0;
        error    = 1'b1;
      end
    endcase
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign word_count = r_word_count;
  assign warn_count = r_warn_count;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised/directed bench for imem_loader with a frame-level reference model.
module tb_imem_loader;

  localparam int AW = 8;
  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready, imem_we, cpu_reset, done, error;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   word_count;
  logic [7:0]    warn_count;

  int vectors = 0;
  int miscompares = 0;

  logic [AW-1:0] got_addr[$];
  logic [31:0]   got_data[$];
  int            bubbles = 0;

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done),
    .error(error), .word_count(word_count), .warn_count(warn_count)
  );

  always #5 clk = ~clk;

  // Write and stall monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
    end
    if (reset === 1'b0 && rx_ready === 1'b0 && done === 1'b0 && error === 1'b0)
      bubbles++;
  end

  function automatic bit op_ok(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                      6'b001000, 6'b001101, 6'b001111, 6'b001010, 6'b000010,
                      6'b000011};
  endfunction

  function automatic bq_t build(input wq_t w, input logic [7:0] csum_flip);
    bq_t  fr;
    logic [7:0] cs = 8'h00;
    fr.push_back(8'hA5);
    fr.push_back(8'(w.size() >> 8));
    fr.push_back(8'(w.size()));
    foreach (w[k]) begin
      for (int b = 3; b >= 0; b--) begin
        fr.push_back(w[k][8*b +: 8]);
        cs ^= w[k][8*b +: 8];
      end
    end
    fr.push_back(cs ^ csum_flip);
    return fr;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard = 0;
    if (gaps) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("rx_ready_timeout", 64'(rx_ready), 64'd1);
    @(negedge clk);
  endtask

  // Send a frame, then compare the DUT against a parse of the same frame
  task automatic run_frame(input string name, input bq_t fr, input bit gaps);
    int         i = 0;
    int         len, warns = 0, base_w, base_b, nw;
    bit         ovf, ok;
    logic [7:0] cs = 8'h00;
    logic [31:0] word;
    wq_t        ew;

    while (i < fr.size() && fr[i] != 8'hA5) i++;
    len = {fr[i+1], fr[i+2]};
    i += 3;
    ovf = (len > (1 << AW));
    if (!ovf) begin
      for (int w = 0; w < len; w++) begin
        word = {fr[i], fr[i+1], fr[i+2], fr[i+3]};
        i += 4;
        cs ^= word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
        ew.push_back(word);
        if (!op_ok(word[31:26])) warns++;
      end
    end
    ok = !ovf && (fr[i] == cs);

    base_w = got_addr.size();
    base_b = bubbles;
    foreach (fr[k]) send_byte(fr[k], gaps);
    rx_valid = 1'b0;

    check({name, ".done"},      64'(done),       64'(ok));
    check({name, ".error"},     64'(error),      64'(!ok));
    check({name, ".cpu_reset"}, 64'(cpu_reset),  64'(!ok));
    check({name, ".rx_ready"},  64'(rx_ready),   64'd0);
    check({name, ".word_count"},64'(word_count), 64'(ew.size()));
    check({name, ".warn_count"},64'(warn_count), 64'(warns > 255 ? 255 : warns));
    check({name, ".writes"},    64'(got_addr.size() - base_w), 64'(ew.size()));
    check({name, ".bubbles"},   64'(bubbles - base_b), 64'(ew.size()));
    nw = got_addr.size() - base_w;
    foreach (ew[k]) begin
      if (k < nw) begin
        check($sformatf("%s.addr%0d", name, k), 64'(got_addr[base_w+k]), 64'(k % (1 << AW)));
        check($sformatf("%s.data%0d", name, k), 64'(got_data[base_w+k]), 64'(ew[k]));
      end
    end
    do_reset();
  endtask

  initial begin
    wq_t w;
    bq_t fr;
    int  base;

    do_reset();
    check("rst.rx_ready",   64'(rx_ready),   64'd1);
    check("rst.imem_we",    64'(imem_we),    64'd0);
    check("rst.imem_addr",  64'(imem_addr),  64'd0);
    check("rst.imem_wdata", 64'(imem_wdata), 64'd0);
    check("rst.cpu_reset",  64'(cpu_reset),  64'd1);
    check("rst.done",       64'(done),       64'd0);
    check("rst.error",      64'(error),      64'd0);
    check("rst.word_count", 64'(word_count), 64'd0);
    check("rst.warn_count", 64'(warn_count), 64'd0);

    w = '{32'h20080005, 32'hAC080010};
    run_frame("two_good", build(w, 8'h00), 1'b0);
    run_frame("two_badcs", '{8'hA5, 8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                             8'hAC, 8'h08, 8'h00, 8'h10, 8'h00}, 1'b0);
    run_frame("garbage", '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h00, 8'h00, 8'h00}, 1'b0);
    run_frame("len_ovf", '{8'hA5, 8'h01, 8'h01}, 1'b0);
    run_frame("bad_op", '{8'hA5, 8'h00, 8'h01, 8'hFC, 8'h00, 8'h00, 8'h00, 8'hFC}, 1'b0);

    base = got_addr.size();
    foreach (fr[k]) fr.delete(k);
    fr = '{8'hA5, 8'h00, 8'h01, 8'h20, 8'h08};
    foreach (fr[k]) send_byte(fr[k], 1'b0);
    do_reset();
    check("midreset.no_write", 64'(got_addr.size() - base), 64'd0);
    w = '{32'h3C01ABCD};
    run_frame("after_reset", build(w, 8'h00), 1'b0);

    w = {};
    for (int k = 0; k < 4; k++) w.push_back($urandom);
    run_frame("rand4_b2b", build(w, 8'h00), 1'b0);
    run_frame("rand4_gaps", build(w, 8'h00), 1'b1);
    run_frame("rand4_badcs", build(w, 8'(1 + $urandom_range(0, 254))), 1'b1);

    w = {};
    for (int k = 0; k < (1 << AW); k++) w.push_back({6'b111111, 26'($urandom)});
    run_frame("full_sat", build(w, 8'h00), 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
